reservation_station: RTL and testbench

Five-entry reservation station for the R10K-style out-of-order core, with one entry per functional-unit class: ALU, FP1, FP2, LD and ST. It sits between dispatch (decode, map table, free list) and the execute stage. It holds dispatched instructions until both source tags are ready, snooping the CDB for wakeups. It issues one ready instruction per cycle.

---
 rtl/reservation_station.sv | 147 ++++++++++++++
 tb/tb_reservation_station.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reservation_station.sv
// Five-entry reservation station (ALU, FP1, FP2, LD, ST) with CDB wakeup and fixed-priority single issue.
// Optional macro RS_CDB_BYPASS_EN: a source matching the current CDB counts as ready for same-cycle issue.
package sys_defs_pkg;
  typedef struct packed {
    logic [5:0] tag;
    logic       ready;
  } TAG;

  typedef enum logic [4:0] {
    ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLTU, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL,
    ALU_SRA, ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
  } ALU_FUNC;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    ALU_FUNC     alu_func;
    logic        rd_mem;
    logic        wr_mem;
    TAG          T;
    TAG          T1;
    TAG          T2;
    logic        valid;
  } ID_EX_PACKET;
endpackage

module reservation_station
  import sys_defs_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  ID_EX_PACKET op,
  input  TAG          T,
  input  TAG          T1,
  input  TAG          T2,
  input  TAG          CDB,
  output logic        rs_busy_alu,
  output logic        rs_busy_fp1,
  output logic        rs_busy_fp2,
  output logic        rs_busy_ld,
  output logic        rs_busy_st,
  output ID_EX_PACKET issue_pkt,
  output logic        issue
);
  localparam int N_RS   = 5;
  localparam int RS_ALU = 0;
  localparam int RS_FP1 = 1;
  localparam int RS_FP2 = 2;
  localparam int RS_LD  = 3;
  localparam int RS_ST  = 4;

  logic [N_RS-1:0] ent_valid;
  ID_EX_PACKET     ent_pkt [N_RS];
  TAG              ent_t   [N_RS];
  TAG              ent_t1  [N_RS];
  TAG              ent_t2  [N_RS];

  TAG              src1_eff [N_RS];
  TAG              src2_eff [N_RS];
  logic [N_RS-1:0] eligible;
  logic [N_RS-1:0] issue_sel;
  logic [N_RS-1:0] disp_sel;
  logic            is_mul;

  function automatic logic cdb_wakes(input logic [5:0] tag, input TAG cdb);
    return cdb.ready && (cdb.tag != '0) && (cdb.tag == tag);
  endfunction

  // Tag 0 is "no register"; a broadcast in the dispatch cycle must not be lost.
  function automatic TAG capture_src(input TAG src, input TAG cdb);
    TAG r;
    r = src;
    if ((src.tag == '0) || cdb_wakes(src.tag, cdb)) r.ready = 1'b1;
    return r;
  endfunction

  always_comb begin
    for (int i = 0; i < N_RS; i++) begin
      src1_eff[i] = ent_t1[i];
      src2_eff[i] = ent_t2[i];
`ifdef RS_CDB_BYPASS_EN
      if (cdb_wakes(ent_t1[i].tag, CDB)) src1_eff[i].ready = 1'b1;
      if (cdb_wakes(ent_t2[i].tag, CDB)) src2_eff[i].ready = 1'b1;
`else
`endif
      eligible[i] = ent_valid[i] && src1_eff[i].ready && src2_eff[i].ready;
    end
  end

  // Index order doubles as issue priority: ALU > FP1 > FP2 > LD > ST.
  always_comb begin
    issue     = 1'b0;
    issue_sel = '0;
    issue_pkt = '0;
    for (int i = 0; i < N_RS; i++) begin
      if (eligible[i] && !issue) begin
        issue        = 1'b1;
        issue_sel[i] = 1'b1;
        issue_pkt    = ent_pkt[i];
        issue_pkt.T  = ent_t[i];
        issue_pkt.T1 = src1_eff[i];
        issue_pkt.T2 = src2_eff[i];
      end
    end
  end

  assign is_mul = op.alu_func inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU};

  // Occupancy is judged before this cycle's issue, so a freeing entry still refuses dispatch.
  always_comb begin
    disp_sel = '0;
    if (op.valid) begin
      if (op.rd_mem)                 disp_sel[RS_LD]  = !ent_valid[RS_LD];
      else if (op.wr_mem)            disp_sel[RS_ST]  = !ent_valid[RS_ST];
      else if (is_mul) begin
        if (!ent_valid[RS_FP1])      disp_sel[RS_FP1] = 1'b1;
        else                         disp_sel[RS_FP2] = !ent_valid[RS_FP2];
      end
      else                           disp_sel[RS_ALU] = !ent_valid[RS_ALU];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) ent_valid <= '0;
    else       ent_valid <= (ent_valid & ~issue_sel) | disp_sel;
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < N_RS; i++) begin
      if (disp_sel[i]) begin
        ent_pkt[i] <= op;
        ent_t[i]   <= T;
        ent_t1[i]  <= capture_src(T1, CDB);
        ent_t2[i]  <= capture_src(T2, CDB);
      end else if (ent_valid[i]) begin
        if (cdb_wakes(ent_t1[i].tag, CDB)) ent_t1[i].ready <= 1'b1;
        if (cdb_wakes(ent_t2[i].tag, CDB)) ent_t2[i].ready <= 1'b1;
      end
    end
  end

  assign rs_busy_alu = ent_valid[RS_ALU];
  assign rs_busy_fp1 = ent_valid[RS_FP1];
  assign rs_busy_fp2 = ent_valid[RS_FP2];
  assign rs_busy_ld  = ent_valid[RS_LD];
  assign rs_busy_st  = ent_valid[RS_ST];
endmodule

// File: tb/tb_reservation_station.sv
// Scoreboard bench for reservation_station: directed scenarios followed by random dispatch/CDB traffic.
module tb_reservation_station;
  import sys_defs_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  ID_EX_PACKET op;
  TAG          T, T1, T2, CDB;
  logic        rs_busy_alu, rs_busy_fp1, rs_busy_fp2, rs_busy_ld, rs_busy_st;
  ID_EX_PACKET issue_pkt;
  logic        issue;

  reservation_station dut (
    .clock(clock), .reset(reset), .op(op), .T(T), .T1(T1), .T2(T2), .CDB(CDB),
    .rs_busy_alu(rs_busy_alu), .rs_busy_fp1(rs_busy_fp1), .rs_busy_fp2(rs_busy_fp2),
    .rs_busy_ld(rs_busy_ld), .rs_busy_st(rs_busy_st), .issue_pkt(issue_pkt), .issue(issue)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct { int cyc; ID_EX_PACKET pkt; } exp_issue_t;
  typedef struct { int cyc; logic [4:0] busy; } exp_busy_t;
  exp_issue_t iss_q[$];
  exp_busy_t  busy_q[$];

  // Reference model: one slot per unit class; readiness derived from the broadcast history.
  typedef struct { bit v; ID_EX_PACKET pkt; TAG t, t1, t2; int dcyc; } slot_t;
  slot_t m[5];
  int    bc_last[64];

  localparam int K_ALU = 0, K_MUL = 1, K_LD = 2, K_ST = 3;

  function automatic TAG mk(input int tag, input bit rdy);
    TAG r;
    r.tag   = tag[5:0];
    r.ready = rdy;
    return r;
  endfunction

  function automatic bit src_ok(input TAG s, input int dcyc);
    return s.ready || (s.tag == 0) || (bc_last[s.tag] >= dcyc);
  endfunction

  task automatic model_cycle(input bit rst, input ID_EX_PACKET o, input TAG t, input TAG t1,
                             input TAG t2, input TAG cdb);
    int c;
    int k;
    int tgt;
    bit cdb_v;
    bit is_mul;
    exp_busy_t  eb;
    exp_issue_t ei;
    c     = cyc;
    cdb_v = cdb.ready && (cdb.tag != 0);
    eb.cyc  = c;
    eb.busy = {m[4].v, m[3].v, m[2].v, m[1].v, m[0].v};
    busy_q.push_back(eb);
`ifdef RS_CDB_BYPASS_EN
    if (cdb_v) bc_last[cdb.tag] = c;
`endif
    k = -1;
    for (int i = 0; i < 5; i++)
      if (k < 0 && m[i].v && src_ok(m[i].t1, m[i].dcyc) && src_ok(m[i].t2, m[i].dcyc)) k = i;
    if (k >= 0) begin
      ei.cyc    = c;
      ei.pkt    = m[k].pkt;
      ei.pkt.T  = m[k].t;
      ei.pkt.T1 = mk(int'(m[k].t1.tag), 1'b1);
      ei.pkt.T2 = mk(int'(m[k].t2.tag), 1'b1);
      iss_q.push_back(ei);
    end
`ifndef RS_CDB_BYPASS_EN
    if (cdb_v) bc_last[cdb.tag] = c;
`endif
    tgt = -1;
    is_mul = (o.alu_func == ALU_MUL) || (o.alu_func == ALU_MULH) ||
             (o.alu_func == ALU_MULHSU) || (o.alu_func == ALU_MULHU);
    if (o.valid) begin
      if (o.rd_mem)      tgt = 3;
      else if (o.wr_mem) tgt = 4;
      else if (is_mul)   tgt = m[1].v ? 2 : 1;
      else               tgt = 0;
      if (m[tgt].v) tgt = -1;
    end
    if (rst) begin
      for (int i = 0; i < 5; i++) m[i].v = 0;
    end else begin
      if (k >= 0) m[k].v = 0;
      if (tgt >= 0) begin
        m[tgt].v    = 1;
        m[tgt].pkt  = o;
        m[tgt].t    = t;
        m[tgt].t1   = t1;
        m[tgt].t2   = t2;
        m[tgt].dcyc = c;
      end
    end
  endtask

  task automatic drive(input bit rst, input bit dv, input int kind, input logic [31:0] inst,
                       input TAG t, input TAG t1, input TAG t2, input TAG cdb);
    ID_EX_PACKET o;
    @(posedge clock);
    #1;
    o.inst   = inst;
    o.pc     = $urandom;
    o.rd_mem = (kind == K_LD);
    o.wr_mem = (kind == K_ST);
    case (kind)
      K_ALU:   o.alu_func = ALU_FUNC'($urandom_range(0, 9));
      K_MUL:   o.alu_func = ALU_FUNC'(10 + $urandom_range(0, 3));
      default: o.alu_func = ALU_FUNC'($urandom_range(0, 17));
    endcase
    o.T     = mk($urandom_range(0, 63), $urandom_range(0, 1) == 1);
    o.T1    = mk($urandom_range(0, 63), $urandom_range(0, 1) == 1);
    o.T2    = mk($urandom_range(0, 63), $urandom_range(0, 1) == 1);
    o.valid = dv;
    reset = rst;
    op    = o;
    T     = t;
    T1    = t1;
    T2    = t2;
    CDB   = cdb;
    model_cycle(rst, o, t, t1, t2, cdb);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, K_ALU, 32'h0, mk(0, 0), mk(0, 0), mk(0, 0), mk(0, 0));
  endtask

  initial begin : monitor
    exp_busy_t  eb;
    exp_issue_t ei;
    forever begin
      @(negedge clock);
      if (busy_q.size() > 0) begin
        eb = busy_q.pop_front();
        n_tests++;
        if ({rs_busy_st, rs_busy_ld, rs_busy_fp2, rs_busy_fp1, rs_busy_alu} !== eb.busy) begin
          n_fail++;
          $display("FAIL busy cyc=%0d got=%b exp=%b", cyc,
                   {rs_busy_st, rs_busy_ld, rs_busy_fp2, rs_busy_fp1, rs_busy_alu}, eb.busy);
        end
      end
      n_tests++;
      if (issue === 1'b1) begin
        if (iss_q.size() == 0) begin
          n_fail++;
          $display("FAIL spurious_issue cyc=%0d got inst=%h exp no issue", cyc, issue_pkt.inst);
        end else begin
          ei = iss_q.pop_front();
          if (ei.cyc != cyc || issue_pkt !== ei.pkt) begin
            n_fail++;
            $display("FAIL issue_pkt cyc=%0d exp_cyc=%0d got=%h exp=%h", cyc, ei.cyc, issue_pkt, ei.pkt);
          end
        end
      end else begin
        if (issue !== 1'b0 || issue_pkt !== '0) begin
          n_fail++;
          $display("FAIL idle_outputs cyc=%0d got issue=%b pkt=%h exp 0", cyc, issue, issue_pkt);
        end else if (iss_q.size() > 0 && iss_q[0].cyc <= cyc) begin
          n_fail++;
          ei = iss_q.pop_front();
          $display("FAIL missing_issue cyc=%0d got issue=0 exp inst=%h at cyc=%0d", cyc, ei.pkt.inst, ei.cyc);
        end
      end
    end
  end

  initial begin : stimulus
    int kind;
    for (int i = 0; i < 64; i++) bc_last[i] = -1;
    for (int i = 0; i < 5; i++) m[i].v = 0;
    reset = 1'b1;
    op    = '0;
    T     = '0;
    T1    = '0;
    T2    = '0;
    CDB   = '0;

    // Reset held two cycles while dispatching.
    drive(1, 1, K_ALU, 32'h1111_1111, mk(4, 0), mk(0, 1), mk(0, 1), mk(0, 0));
    drive(1, 1, K_ALU, 32'h2222_2222, mk(4, 0), mk(0, 1), mk(0, 1), mk(0, 0));
    idle(2);
    // Ready ALU instruction issues the cycle after dispatch.
    drive(0, 1, K_ALU, 32'hDEAD_BEEF, mk(5, 0), mk(3, 1), mk(0, 1), mk(0, 0));
    idle(3);
    // Waits on tag 7 until broadcast.
    drive(0, 1, K_ALU, 32'hA000_0007, mk(6, 0), mk(7, 0), mk(0, 1), mk(0, 0));
    idle(3);
    drive(0, 0, K_ALU, 32'h0, mk(0, 0), mk(0, 0), mk(0, 0), mk(7, 1));
    idle(2);
    // FP1 then FP2 fill; third multiply refused.
    drive(0, 1, K_MUL, 32'hF100_0001, mk(10, 0), mk(7, 0), mk(0, 1), mk(0, 0));
    drive(0, 1, K_MUL, 32'hF200_0002, mk(11, 0), mk(7, 0), mk(0, 1), mk(0, 0));
    drive(0, 1, K_MUL, 32'hF300_0003, mk(12, 0), mk(7, 0), mk(0, 1), mk(0, 0));
    idle(2);
    drive(0, 0, K_ALU, 32'h0, mk(0, 0), mk(0, 0), mk(0, 0), mk(7, 1));
    idle(3);
    // ALU and LD become ready together.
    drive(0, 1, K_ALU, 32'hA100_0000, mk(13, 0), mk(7, 0), mk(0, 1), mk(0, 0));
    drive(0, 1, K_LD,  32'hB100_0000, mk(14, 0), mk(0, 1), mk(7, 0), mk(0, 0));
    drive(0, 0, K_ALU, 32'h0, mk(0, 0), mk(0, 0), mk(0, 0), mk(7, 1));
    idle(3);
    // Broadcast coinciding with dispatch, and a non-valid broadcast.
    drive(0, 1, K_ALU, 32'hC900_0001, mk(15, 0), mk(9, 0), mk(0, 1), mk(9, 1));
    idle(2);
    drive(0, 1, K_ALU, 32'hC900_0002, mk(15, 0), mk(9, 0), mk(0, 1), mk(9, 0));
    idle(2);
    drive(0, 0, K_ALU, 32'h0, mk(0, 0), mk(0, 0), mk(0, 0), mk(9, 1));
    idle(2);
    // ST entry and tag-0 CDB that must not wake anything.
    drive(0, 1, K_ST, 32'h5700_0000, mk(16, 0), mk(3, 0), mk(0, 0), mk(0, 1));
    idle(2);
    drive(0, 0, K_ALU, 32'h0, mk(0, 0), mk(0, 0), mk(0, 0), mk(3, 1));
    idle(2);

    for (int n = 0; n < 3000; n++) begin
      kind = $urandom_range(0, 9);
      kind = (kind < 4) ? K_ALU : (kind < 7) ? K_MUL : (kind < 9) ? K_LD : K_ST;
      drive($urandom_range(0, 299) == 0, $urandom_range(0, 1) == 1, kind, $urandom,
            mk($urandom_range(0, 63), $urandom_range(0, 1) == 1),
            mk($urandom_range(0, 7), $urandom_range(0, 3) == 0),
            mk($urandom_range(0, 7), $urandom_range(0, 3) == 0),
            mk($urandom_range(0, 7), $urandom_range(0, 2) == 0));
    end
    for (int n = 0; n < 20; n++)
      drive(0, 0, K_ALU, 32'h0, mk(0, 0), mk(0, 0), mk(0, 0), mk(1 + (n % 7), 1));
    idle(3);
    @(negedge clock);
    #1;
    n_tests++;
    if (iss_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover_issues got=%0d exp=0", iss_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
